// File: rtl/fir_filter_mc.sv
// Multi-channel time-multiplexed FIR: one shared serial MAC walks the taps of the
// selected channel's delay line, then rounds/saturates the sum into a held output.

module fir_line #(
  parameter int N   = 3,
  parameter int W_X = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 shift_en,
  input  logic [W_X-1:0]       din,
  output logic [N:0][W_X-1:0]  taps
);
  logic [N:0][W_X-1:0] taps_q, taps_d;

  always_comb begin
    taps_d = taps_q;
    if (shift_en) begin
      taps_d[0] = din;
      for (int i = 1; i <= N; i++) taps_d[i] = taps_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) taps_q <= '0;
    else       taps_q <= taps_d;
  end

  assign taps = taps_q;
endmodule

module fir_filter_mc #(
  parameter int C     = 4,
  parameter int N     = 3,
  parameter int W_X   = 4,
  parameter int W_K   = 4,
  parameter int W_OUT = W_X + W_K + $clog2(N+1),
  parameter int SHIFT = 0,
  parameter logic [N:0][W_K-1:0] K = {4'd4, 4'd3, 4'd2, 4'd1},
  localparam int CW = (C > 1) ? $clog2(C) : 1,
  localparam int AW = (N > 0) ? $clog2(N+1) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [W_X-1:0]    s_data,
  input  logic [CW-1:0]     s_chan,
  input  logic              k_wr,
  input  logic [AW-1:0]     k_addr,
  input  logic [W_K-1:0]    k_data,
  input  logic              k_commit,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [W_OUT-1:0]  m_data,
  output logic [CW-1:0]     m_chan,
  output logic              m_sat,
  output logic              err_chan
);
  localparam int W_ACC = W_X + W_K + $clog2(N+1);
  localparam int W_P   = W_X + W_K;
  // Rounding/saturation run wide enough that neither the rounding add nor the
  // range limits can wrap, whatever W_OUT is relative to W_ACC.
  localparam int W_E   = ((W_ACC + 1 > W_OUT) ? W_ACC + 1 : W_OUT) + 1;
  localparam logic signed [W_E-1:0] RND  =
    (SHIFT > 0) ? (W_E'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [W_E-1:0] OMAX = {{(W_E-W_OUT+1){1'b0}}, {(W_OUT-1){1'b1}}};
  localparam logic signed [W_E-1:0] OMIN = {{(W_E-W_OUT+1){1'b1}}, {(W_OUT-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t                   state_q, state_d;
  logic [N:0][W_K-1:0]      shadow_q, shadow_d, active_q, active_d;
  logic                     pend_q, pend_d;
  logic [CW-1:0]            ch_q, ch_d;
  logic [AW-1:0]            idx_q, idx_d;
  logic signed [W_ACC-1:0]  acc_q, acc_d;
  logic                     mv_q, mv_d;
  logic [W_OUT-1:0]         md_q, md_d;
  logic [CW-1:0]            mc_q, mc_d;
  logic                     ms_q, ms_d;
  logic                     err_q, err_d;

  logic [C-1:0][N:0][W_X-1:0] line;
  logic                       accept, chan_ok, addr_ok;
  logic signed [W_P-1:0]      prod;
  logic signed [W_ACC-1:0]    sum;
  logic signed [W_E-1:0]      ext, rsh;

  assign s_ready = rstn && (state_q == S_IDLE);
  assign accept  = s_valid && s_ready;
  assign chan_ok = 32'(s_chan) < 32'(C);
  assign addr_ok = 32'(k_addr) <= 32'(N);

  for (genvar g = 0; g < C; g++) begin : g_line
    fir_line #(.N(N), .W_X(W_X)) u_line (
      .clk      (clk),
      .rstn     (rstn),
      .shift_en (accept && chan_ok && (s_chan == CW'(g))),
      .din      (s_data),
      .taps     (line[g])
    );
  end

  assign prod = $signed(line[ch_q][idx_q]) * $signed(active_q[idx_q]);
  assign sum  = acc_q + W_ACC'(prod);
  assign ext  = W_E'(sum) + RND;
  assign rsh  = ext >>> SHIFT;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    pend_d   = pend_q | k_commit;
    ch_d     = ch_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    mv_d     = mv_q;
    md_d     = md_q;
    mc_d     = mc_q;
    ms_d     = ms_q;
    err_d    = 1'b0;

    if (k_wr && addr_ok) shadow_d[k_addr] = k_data;
    // Copy takes the post-write shadow, so a same-edge write is included.
    if (state_q == S_IDLE && pend_d) begin
      active_d = shadow_d;
      pend_d   = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (chan_ok) begin
            ch_d    = s_chan;
            acc_d   = '0;
            idx_d   = '0;
            state_d = S_MAC;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_MAC: begin
        acc_d = sum;
        idx_d = idx_q + 1'b1;
        if (idx_q == AW'(N)) begin
          mv_d    = 1'b1;
          mc_d    = ch_q;
          state_d = S_OUT;
          if (rsh > OMAX) begin
            md_d = OMAX[W_OUT-1:0];
            ms_d = 1'b1;
          end else if (rsh < OMIN) begin
            md_d = OMIN[W_OUT-1:0];
            ms_d = 1'b1;
          end else begin
            md_d = rsh[W_OUT-1:0];
            ms_d = 1'b0;
          end
        end
      end
      S_OUT: begin
        if (m_ready) begin
          mv_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      shadow_q <= K;
      active_q <= K;
      pend_q   <= 1'b0;
      ch_q     <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      mv_q     <= 1'b0;
      md_q     <= '0;
      mc_q     <= '0;
      ms_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      ch_q     <= ch_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      mv_q     <= mv_d;
      md_q     <= md_d;
      mc_q     <= mc_d;
      ms_q     <= ms_d;
      err_q    <= err_d;
    end
  end

  assign m_valid  = mv_q;
  assign m_data   = md_q;
  assign m_chan   = mc_q;
  assign m_sat    = ms_q;
  assign err_chan = err_q;
endmodule

// File: tb/tb_fir_filter_mc.sv
// Three lockstep instances share stimulus: default widths, 8-bit saturating, and
// 8-bit with SHIFT=2; a scoreboard predicts every output of all three.

module tb_fir_filter_mc;
  localparam int C = 3;
  localparam int N = 3;

  logic clk = 1'b0, rstn = 1'b0;
  logic s_valid = 1'b0, k_wr = 1'b0, k_commit = 1'b0, m_ready = 1'b1;
  logic [3:0] s_data = '0, k_data = '0;
  logic [1:0] s_chan = '0, k_addr = '0;

  logic s_ready0, s_ready1, s_ready2, m_valid0, m_valid1, m_valid2;
  logic m_sat0, m_sat1, m_sat2, err0, err1, err2;
  logic [9:0] m_data0;
  logic [7:0] m_data1, m_data2;
  logic [1:0] m_chan0, m_chan1, m_chan2;

  fir_filter_mc #(.C(C)) dut0 (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data),
    .s_chan(s_chan), .k_wr(k_wr), .k_addr(k_addr), .k_data(k_data), .k_commit(k_commit),
    .m_valid(m_valid0), .m_ready(m_ready), .m_data(m_data0), .m_chan(m_chan0),
    .m_sat(m_sat0), .err_chan(err0));

  fir_filter_mc #(.C(C), .W_OUT(8), .SHIFT(0), .K({4'd7, 4'd7, 4'd7, 4'd7})) dut1 (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data),
    .s_chan(s_chan), .k_wr(k_wr), .k_addr(k_addr), .k_data(k_data), .k_commit(k_commit),
    .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1), .m_chan(m_chan1),
    .m_sat(m_sat1), .err_chan(err1));

  fir_filter_mc #(.C(C), .W_OUT(8), .SHIFT(2), .K({4'd7, 4'd7, 4'd7, 4'd7})) dut2 (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready2), .s_data(s_data),
    .s_chan(s_chan), .k_wr(k_wr), .k_addr(k_addr), .k_data(k_data), .k_commit(k_commit),
    .m_valid(m_valid2), .m_ready(m_ready), .m_data(m_data2), .m_chan(m_chan2),
    .m_sat(m_sat2), .err_chan(err2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int ch; int d0; int s0; int d1; int s1; int d2; int s2; int acc;
  } exp_t;
  exp_t sb_q[$];

  int n_chk = 0, n_err = 0;
  int ml[C][N+1];
  int k0[N+1], k12[N+1], sh0[N+1], sh12[N+1];
  bit mv_prev = 1'b0;
  bit bp_done = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int rnd(input int a, input int sh);
    return (sh > 0) ? ((a + (1 << (sh - 1))) >>> sh) : a;
  endfunction

  function automatic int clampv(input int r, input int w);
    int mx = (1 << (w - 1)) - 1;
    int mn = -(1 << (w - 1));
    return (r > mx) ? mx : ((r < mn) ? mn : r);
  endfunction

  function automatic int satf(input int r, input int w);
    return (r > (1 << (w - 1)) - 1 || r < -(1 << (w - 1))) ? 1 : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    foreach (ml[c, i]) ml[c][i] = 0;
    k0   = '{1, 2, 3, 4};
    sh0  = '{1, 2, 3, 4};
    k12  = '{7, 7, 7, 7};
    sh12 = '{7, 7, 7, 7};
    sb_q.delete();
  endtask

  task automatic kwrite(input int a, input int d);
    k_wr = 1'b1; k_addr = a[1:0]; k_data = d[3:0];
    sh0[a] = d; sh12[a] = d;
    tick();
    k_wr = 1'b0;
  endtask

  // Drives one sample (optionally with same-edge k_commit/k_wr) and predicts its output.
  task automatic send(input int ch, input int x, input bit cm = 1'b0,
                      input bit kw = 1'b0, input int ka = 0, input int kd = 0);
    int n = 0;
    int a0 = 0, a12 = 0;
    exp_t e;
    s_valid = 1'b1; s_chan = ch[1:0]; s_data = x[3:0];
    k_commit = cm; k_wr = kw; k_addr = ka[1:0]; k_data = kd[3:0];
    while (!s_ready0 && n < 200) begin tick(); n++; end
    chk("send_accept", s_ready0, 1);
    if (kw) begin sh0[ka] = kd; sh12[ka] = kd; end
    if (cm) begin k0 = sh0; k12 = sh12; end
    if (ch < C) begin
      for (int i = N; i > 0; i--) ml[ch][i] = ml[ch][i-1];
      ml[ch][0] = x;
      for (int i = 0; i <= N; i++) begin
        a0  += ml[ch][i] * k0[i];
        a12 += ml[ch][i] * k12[i];
      end
      e.ch = ch;
      e.d0 = clampv(rnd(a0, 0), 10);  e.s0 = satf(rnd(a0, 0), 10);
      e.d1 = clampv(rnd(a12, 0), 8);  e.s1 = satf(rnd(a12, 0), 8);
      e.d2 = clampv(rnd(a12, 2), 8);  e.s2 = satf(rnd(a12, 2), 8);
      e.acc = cyc + 1;
      sb_q.push_back(e);
    end
    tick();
    s_valid = 1'b0; k_commit = 1'b0; k_wr = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() > 0 && n < 100) begin tick(); n++; end
    chk("drain", sb_q.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (m_valid0 && !mv_prev && sb_q.size() > 0)
      chk("latency", cyc - sb_q[0].acc, N + 1);
    if (m_valid0 && m_ready) begin
      if (sb_q.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        e = sb_q.pop_front();
        chk("d0", int'($signed(m_data0)), e.d0);
        chk("chan0", int'(m_chan0), e.ch);
        chk("sat0", int'(m_sat0), e.s0);
        chk("d1", int'($signed(m_data1)), e.d1);
        chk("sat1", int'(m_sat1), e.s1);
        chk("d2", int'($signed(m_data2)), e.d2);
        chk("sat2", int'(m_sat2), e.s2);
      end
    end
    mv_prev = m_valid0;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int imp[5] = '{1, 0, 0, 0, 0};
    model_reset();
    tick(); tick();
    chk("rst_m_valid", m_valid0, 0);
    chk("rst_m_data", int'(m_data0), 0);
    chk("rst_m_chan", int'(m_chan0), 0);
    chk("rst_m_sat", m_sat0, 0);
    chk("rst_err", err0, 0);
    chk("rst_s_ready", s_ready0, 0);
    rstn = 1'b1;
    tick();
    chk("idle_s_ready", s_ready0, 1);

    // impulse on ch0 with default coefficients
    foreach (imp[i]) send(0, imp[i]);
    drain();

    // interleaved channels, no cross-talk
    send(0, 1); send(1, -8);
    repeat (4) begin send(0, 0); send(1, 0); end
    drain();

    // backpressure held in OUT while a second sample waits
    m_ready = 1'b0;
    send(0, 5);
    fork begin send(0, -3); bp_done = 1'b1; end join_none
    n = 0;
    while (!m_valid0 && n < 20) begin tick(); n++; end
    chk("bp_valid", m_valid0, 1);
    repeat (10) begin
      chk("bp_s_ready", s_ready0, 0);
      chk("bp_hold", int'($signed(m_data0)), sb_q[0].d0);
      tick();
    end
    m_ready = 1'b1;
    n = 0;
    while (!bp_done && n < 100) begin tick(); n++; end
    chk("bp_second_accepted", bp_done, 1);
    drain();

    // saturation (dut1) and rounding shift (dut2)
    repeat (4) send(0, -8);
    drain();

    // commit during MAC: current sample keeps old bank, next one uses new
    kwrite(0, 1); kwrite(1, 0); kwrite(2, 0); kwrite(3, 0);
    send(0, 3);
    k_commit = 1'b1; tick(); k_commit = 1'b0;
    k0 = sh0; k12 = sh12;
    drain();
    send(0, 2);
    drain();
    // commit + shadow write + accept all on one IDLE edge
    kwrite(0, 1); kwrite(1, 1); kwrite(2, 1);
    send(0, 1, 1'b1, 1'b1, 3, 1);
    drain();

    // invalid channel is dropped with an error pulse
    send(C, 5);
    chk("err_pulse", err0, 1);
    tick();
    chk("err_clear", err0, 0);
    chk("err_no_valid", m_valid0, 0);

    // reset during MAC abandons the result and clears lines and banks
    send(0, 5);
    rstn = 1'b0;
    model_reset();
    tick();
    chk("mid_rst_valid", m_valid0, 0);
    chk("mid_rst_s_ready", s_ready0, 0);
    tick();
    rstn = 1'b1;
    tick();
    foreach (imp[i]) if (i < 4) send(0, imp[i]);
    send(1, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
